rptr_handler_lvl: RTL and testbench

- Parametrised read-side pointer handler for the async FIFO. Runs in the read clock domain.
- Advances the binary and Gray read pointers on accepted reads and produces a registered empty flag.
- Adds what the previous read handler lacked:
  - a dedicated rd_en input, so the read pointer no longer advances on wr_en;
  - occupancy (fill level) as seen from the read side;
  - a programmable almost-empty flag;
  - underflow detection.
- Consumes the write pointer after it has passed through the 2-flop Gray synchroniser.

---
 rtl/fifo_ptr_pkg.sv | 21 ++
 rtl/gray2bin_conv.sv | 26 ++
 rtl/rptr_handler_lvl.sv | 102 ++++++++++
 tb/tb_rptr_handler_lvl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ptr_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ptr_pkg
// Helpers shared by the async FIFO read- and write-pointer handlers.
//   ptr_w()    : pointer width for a given number of address bits
//                (address bits plus one wrap bit).
//   bin2gray() : binary to reflected Gray conversion. It works on a 32-bit
//                container; callers cast to and from their own pointer width.
// -----------------------------------------------------------------------------
package fifo_ptr_pkg;

  localparam int GRAY_CONT_W = 32;

  function automatic int ptr_w(input int addr_bits);
    return addr_bits + 32'sd1;
  endfunction

  function automatic logic [GRAY_CONT_W-1:0] bin2gray(input logic [GRAY_CONT_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// -----------------------------------------------------------------------------
// gray2bin_conv
// Purely combinational Gray to binary converter.
// Parameters:
//   WIDTH : vector width
// Ports:
//   gray  in  WIDTH  Gray-coded value
//   bin   out WIDTH  binary value
// Each binary bit is the XOR of all Gray bits from the MSB down to that bit.
// -----------------------------------------------------------------------------
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Prefix XOR from the MSB, expressed per bit as the reduction of a shifted copy.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/rptr_handler_lvl.sv
// -----------------------------------------------------------------------------
// rptr_handler_lvl
// Read-side pointer handler for the async FIFO (read clock domain).
// Advances binary/Gray read pointers on accepted reads and produces registered
// empty, almost-empty, occupancy and underflow indications.
//
// Parameters:
//   PTR_WIDTH : address bits, FIFO depth = 2**PTR_WIDTH
//   AE_THRESH : almost_empty when occupancy <= AE_THRESH
// Ports:
//   rdclk        in   read clock
//   rrst         in   asynchronous active-high reset
//   rd_en        in   read request
//   g_wptr_sync  in   Gray write pointer already synchronised into rdclk
//   clr_err      in   clears sticky underflow (sticky build only)
//   b_rptr       out  binary read pointer (low bits = RAM read address)
//   g_rptr       out  Gray read pointer for the write-domain synchroniser
//   fifo_empty   out  registered empty flag
//   almost_empty out  registered occupancy <= AE_THRESH
//   rd_count     out  registered occupancy 0 .. 2**PTR_WIDTH
//   underflow    out  read attempted while empty
//
// Build option: define RPTR_UNDERFLOW_STICKY_EN to make underflow sticky until
// clr_err (a new underflow in the clearing cycle wins). Without it underflow
// is a one-cycle pulse and clr_err is ignored.
// -----------------------------------------------------------------------------
import fifo_ptr_pkg::*;

module rptr_handler_lvl #(
  parameter int PTR_WIDTH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                 rdclk,
  input  logic                 rrst,
  input  logic                 rd_en,
  input  logic [PTR_WIDTH:0]   g_wptr_sync,
  input  logic                 clr_err,
  output logic [PTR_WIDTH:0]   b_rptr,
  output logic [PTR_WIDTH:0]   g_rptr,
  output logic                 fifo_empty,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   rd_count,
  output logic                 underflow
);

  localparam int PW = ptr_w(PTR_WIDTH);
  localparam logic [PW-1:0] AE_LIM = AE_THRESH[PW-1:0];

  logic          rd_acc;
  logic [PW-1:0] b_next;
  logic [PW-1:0] g_next;
  logic [PW-1:0] b_wptr_sync;
  logic [PW-1:0] occ_next;

  gray2bin_conv #(
    .WIDTH (PW)
  ) u_wptr_g2b (
    .gray (g_wptr_sync),
    .bin  (b_wptr_sync)
  );

`ifndef RPTR_UNDERFLOW_STICKY_EN
  // clr_err only matters for the sticky build.
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
`endif

  // Next read pointer and occupancy; the occupancy already accounts for the
  // read being accepted this cycle, so a same-cycle read+write nets to zero.
  always_comb begin
    rd_acc   = rd_en & ~fifo_empty;
    b_next   = b_rptr + {{(PW-1){1'b0}}, rd_acc};
    g_next   = PW'(bin2gray(GRAY_CONT_W'(b_next)));
    occ_next = b_wptr_sync - b_next;
  end

  // Pointer, flag and occupancy registers.
  always_ff @(posedge rdclk or posedge rrst) begin
    if (rrst) begin
      b_rptr       <= '0;
      g_rptr       <= '0;
      fifo_empty   <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      underflow    <= 1'b0;
    end else begin
      b_rptr       <= b_next;
      g_rptr       <= g_next;
      // Gray compare: equal pointers including the wrap bit means empty.
      fifo_empty   <= (g_next == g_wptr_sync);
      rd_count     <= occ_next;
      almost_empty <= (occ_next <= AE_LIM);
`ifdef RPTR_UNDERFLOW_STICKY_EN
      // Set has priority over clear.
      underflow    <= (rd_en & fifo_empty) | (underflow & ~clr_err);
`else
      underflow    <= rd_en & fifo_empty;
`endif
    end
  end

endmodule

// File: tb/tb_rptr_handler_lvl.sv
// -----------------------------------------------------------------------------
// tb_rptr_handler_lvl
// Self-checking bench for rptr_handler_lvl (PTR_WIDTH=3, AE_THRESH=1).
// Reference model tracks absolute write/read counts as integers; occupancy is
// their difference modulo 16, empty is zero occupancy.
// -----------------------------------------------------------------------------
module tb_rptr_handler_lvl;

  localparam int PTR_WIDTH = 3;
  localparam int AE_THRESH = 1;
  localparam int DEPTH = 8;

  logic       rdclk;
  logic       rrst;
  logic       rd_en;
  logic [3:0] g_wptr_sync;
  logic       clr_err;
  logic [3:0] b_rptr;
  logic [3:0] g_rptr;
  logic       fifo_empty;
  logic       almost_empty;
  logic [3:0] rd_count;
  logic       underflow;

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model state
  int m_w;     // absolute writes visible through the synchroniser
  int m_r;     // absolute accepted reads
  bit m_empty;
  bit m_ae;
  int m_cnt;
  bit m_uf;

  rptr_handler_lvl #(
    .PTR_WIDTH (PTR_WIDTH),
    .AE_THRESH (AE_THRESH)
  ) dut (
    .rdclk        (rdclk),
    .rrst         (rrst),
    .rd_en        (rd_en),
    .g_wptr_sync  (g_wptr_sync),
    .clr_err      (clr_err),
    .b_rptr       (b_rptr),
    .g_rptr       (g_rptr),
    .fifo_empty   (fifo_empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .underflow    (underflow)
  );

  initial rdclk = 1'b0;
  always #5 rdclk = ~rdclk;

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] exp_b();
    return m_r[3:0];
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = 0; m_empty = 1'b1; m_ae = 1'b1; m_cnt = 0; m_uf = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return #1 after.
  task automatic tick(input bit rd, input bit clr, input int w);
    bit acc;
    int occ;
    @(negedge rdclk);
    rd_en = rd;
    clr_err = clr;
    g_wptr_sync = gray4(w);
    @(posedge rdclk);
    acc = rd && !m_empty;
`ifdef RPTR_UNDERFLOW_STICKY_EN
    m_uf = (rd && m_empty) || (m_uf && !clr);
`else
    m_uf = rd && m_empty;
`endif
    m_w = w;
    m_r = m_r + (acc ? 1 : 0);
    occ = (m_w - m_r) & 15;
    m_cnt = occ;
    m_empty = (occ == 0);
    m_ae = (occ <= AE_THRESH);
    #1;
  endtask

  task automatic test_reset();
    rrst = 1'b1; rd_en = 1'b0; clr_err = 1'b0; g_wptr_sync = 4'd0;
    model_reset();
    #1;
    total_cnt++;
    if ({b_rptr, g_rptr, rd_count, fifo_empty, almost_empty, underflow} !== {4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0})
      $display("FAIL reset_hold got b=%h g=%h cnt=%0d e=%b ae=%b uf=%b want 0 0 0 1 1 0",
               b_rptr, g_rptr, rd_count, fifo_empty, almost_empty, underflow);
    else pass_cnt++;
    repeat (2) @(negedge rdclk);
    rrst = 1'b0;
    tick(1'b0, 1'b0, 0);
    total_cnt++;
    if ({b_rptr, g_rptr, rd_count, fifo_empty, almost_empty, underflow} !== {4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0})
      $display("FAIL reset_release got b=%h g=%h cnt=%0d e=%b ae=%b uf=%b want 0 0 0 1 1 0",
               b_rptr, g_rptr, rd_count, fifo_empty, almost_empty, underflow);
    else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 5; i++) begin
      tick(1'b0, 1'b0, i);
      total_cnt++;
      if (rd_count !== 4'(i) || fifo_empty !== 1'b0 || almost_empty !== (i <= 1))
        $display("FAIL fill_%0d got cnt=%0d e=%b ae=%b want cnt=%0d e=0 ae=%b",
                 i, rd_count, fifo_empty, almost_empty, i, (i <= 1));
      else pass_cnt++;
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, m_w);
      total_cnt++;
      if (rd_count !== 4'(m_cnt) || fifo_empty !== m_empty || almost_empty !== m_ae ||
          underflow !== m_uf || b_rptr !== exp_b())
        $display("FAIL drain_%0d got cnt=%0d e=%b ae=%b uf=%b b=%h want cnt=%0d e=%b ae=%b uf=%b b=%h",
                 i, rd_count, fifo_empty, almost_empty, underflow, b_rptr,
                 m_cnt, m_empty, m_ae, m_uf, exp_b());
      else pass_cnt++;
    end
    // the final underflow (from the 8th read) must be visible
    total_cnt++;
    if (underflow !== 1'b1 || b_rptr !== 4'd5)
      $display("FAIL drain_end got uf=%b b=%h want uf=1 b=5", underflow, b_rptr);
    else pass_cnt++;
    tick(1'b0, 1'b1, m_w);
    total_cnt++;
    if (underflow !== 1'b0)
      $display("FAIL drain_idle got uf=%b want 0", underflow);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit saw_wrap = 1'b0;
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int k = 0; k < DEPTH; k++) tick(1'b0, 1'b0, m_w + 1);
      for (int k = 0; k < DEPTH; k++) begin
        tick(1'b1, 1'b0, m_w);
        if (b_rptr == 4'd0) saw_wrap = 1'b1;
        total_cnt++;
        if (b_rptr !== exp_b() || g_rptr !== gray4(m_r) || fifo_empty !== m_empty || rd_count !== 4'(m_cnt))
          $display("FAIL wrap_%0d_%0d got b=%h g=%h e=%b cnt=%0d want b=%h g=%h e=%b cnt=%0d",
                   rnd, k, b_rptr, g_rptr, fifo_empty, rd_count,
                   exp_b(), gray4(m_r), m_empty, m_cnt);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (saw_wrap !== 1'b1 || b_rptr !== 4'd5 || fifo_empty !== 1'b1)
      $display("FAIL wrap_cross got seen=%b b=%h e=%b want seen=1 b=5 e=1", saw_wrap, b_rptr, fifo_empty);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, m_w + 1);
    tick(1'b0, 1'b0, m_w);
    total_cnt++;
    if (rd_count !== 4'd3)
      $display("FAIL simul_pre got cnt=%0d want 3", rd_count);
    else pass_cnt++;
    tick(1'b1, 1'b0, m_w + 1);
    total_cnt++;
    if (rd_count !== 4'd3 || fifo_empty !== 1'b0 || b_rptr !== exp_b())
      $display("FAIL simul got cnt=%0d e=%b b=%h want cnt=3 e=0 b=%h", rd_count, fifo_empty, b_rptr, exp_b());
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit rd;
      bit clr;
      int w;
      rd = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 7) == 0);
      w = m_w;
      if ($urandom_range(0, 1) == 1 && (m_w + 1 - m_r) <= DEPTH) w = m_w + 1;
      tick(rd, clr, w);
      total_cnt++;
      if (b_rptr !== exp_b() || g_rptr !== gray4(m_r) || fifo_empty !== m_empty ||
          almost_empty !== m_ae || rd_count !== 4'(m_cnt) || underflow !== m_uf)
        $display("FAIL rand_%0d got b=%h g=%h e=%b ae=%b cnt=%0d uf=%b want b=%h g=%h e=%b ae=%b cnt=%0d uf=%b",
                 i, b_rptr, g_rptr, fifo_empty, almost_empty, rd_count, underflow,
                 exp_b(), gray4(m_r), m_empty, m_ae, m_cnt, m_uf);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 16 && !m_empty; k++) tick(1'b1, 1'b1, m_w);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, m_w + 1);
    tick(1'b0, 1'b0, m_w);
    total_cnt++;
    if (rd_count !== 4'd4)
      $display("FAIL mid_pre got cnt=%0d want 4", rd_count);
    else pass_cnt++;
    #2;
    rrst = 1'b1;
    g_wptr_sync = 4'd0;
    model_reset();
    #1;
    total_cnt++;
    if ({b_rptr, g_rptr, rd_count, fifo_empty, almost_empty, underflow} !== {4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0})
      $display("FAIL mid_reset got b=%h g=%h cnt=%0d e=%b ae=%b uf=%b want 0 0 0 1 1 0",
               b_rptr, g_rptr, rd_count, fifo_empty, almost_empty, underflow);
    else pass_cnt++;
    @(negedge rdclk);
    rrst = 1'b0;
    tick(1'b0, 1'b0, 1);
    total_cnt++;
    if (rd_count !== 4'd1 || fifo_empty !== 1'b0 || b_rptr !== 4'd0)
      $display("FAIL mid_after got cnt=%0d e=%b b=%h want cnt=1 e=0 b=0", rd_count, fifo_empty, b_rptr);
    else pass_cnt++;
  endtask

  task automatic test_underflow();
    bit hold_exp;
    for (int k = 0; k < 4 && !m_empty; k++) tick(1'b1, 1'b1, m_w);
    tick(1'b0, 1'b1, m_w);
    tick(1'b1, 1'b0, m_w);
    total_cnt++;
    if (underflow !== 1'b1)
      $display("FAIL uf_set got %b want 1", underflow);
    else pass_cnt++;
`ifdef RPTR_UNDERFLOW_STICKY_EN
    hold_exp = 1'b1;
`else
    hold_exp = 1'b0;
`endif
    tick(1'b0, 1'b0, m_w);
    tick(1'b0, 1'b0, m_w);
    total_cnt++;
    if (underflow !== hold_exp || underflow !== m_uf)
      $display("FAIL uf_hold got %b want %b", underflow, hold_exp);
    else pass_cnt++;
    tick(1'b1, 1'b1, m_w);
    total_cnt++;
    if (underflow !== 1'b1)
      $display("FAIL uf_set_vs_clr got %b want 1", underflow);
    else pass_cnt++;
    tick(1'b0, 1'b1, m_w);
    total_cnt++;
    if (underflow !== 1'b0)
      $display("FAIL uf_clear got %b want 0", underflow);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_random();
    test_reset_mid();
    test_underflow();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
